// File: rtl/r2fft_dma_reader.sv
// Streams one FFT frame out of the core's DMA read port onto a valid/ready bus.
// Define R2FFT_DMARD_BITREV_EN to issue reads in bit-reversed address order.
module r2fft_dma_reader #(
    parameter int FFT_LENGTH = 1024,
    parameter int FFT_DW     = 16,
    parameter int RD_LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     done_i,
    input  logic signed [7:0]        bfpexp_i,
    output logic                     dmaact_o,
    output logic [$clog2(FFT_LENGTH)-1:0] dmaa_o,
    input  logic signed [FFT_DW-1:0] dmadr_real_i,
    input  logic signed [FFT_DW-1:0] dmadr_imag_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic signed [FFT_DW-1:0] m_real_o,
    output logic signed [FFT_DW-1:0] m_imag_o,
    output logic                     m_first_o,
    output logic                     m_last_o,
    output logic signed [7:0]        m_exp_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam int FFT_N = $clog2(FFT_LENGTH);
    localparam int DEPTH = RD_LATENCY + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam logic [FFT_N-1:0] LAST_ADDR = FFT_N'(FFT_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t state_q, state_d;
    logic [FFT_N-1:0] cnt_q;
    logic signed [7:0] exp_q;
    logic overrun_q;
    logic start, issue, push, pop;

    logic [RD_LATENCY-1:0] pv, pf, pl;
    logic [4:0] inflight, fcount, occ;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic signed [FFT_DW-1:0] mem_re [DEPTH];
    logic signed [FFT_DW-1:0] mem_im [DEPTH];
    logic mem_f [DEPTH];
    logic mem_l [DEPTH];

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [FFT_N-1:0] bitrev(input logic [FFT_N-1:0] a);
        logic [FFT_N-1:0] r;
        r = '0;
        for (int i = 0; i < FFT_N; i++) r[i] = a[FFT_N-1-i];
        return r;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + {4'b0, pv[i]};
    end

    assign m_valid_o = (fcount != '0);
    assign pop       = m_valid_o && m_ready_i;
    assign push      = pv[RD_LATENCY-1];
    // A word leaving this cycle frees its slot in time for a new strobe.
    assign occ       = inflight + fcount - {4'b0, pop};

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (done_i) begin
                    start   = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                if (occ < 5'(DEPTH)) begin
                    issue = 1'b1;
                    if (cnt_q == LAST_ADDR) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_last_o) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            exp_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= done_i && (state_q != IDLE);
            if (start) begin
                cnt_q <= '0;
                exp_q <= bfpexp_i;
            end else if (issue && cnt_q != LAST_ADDR) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pf <= '0;
            pl <= '0;
        end else begin
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pf[i] <= pf[i-1];
                pl[i] <= pl[i-1];
            end
            pv[0] <= issue;
            pf[0] <= issue && (cnt_q == '0);
            pl[0] <= issue && (cnt_q == LAST_ADDR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
                mem_f[i]  <= 1'b0;
                mem_l[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_re[wr_ptr] <= dmadr_real_i;
                mem_im[wr_ptr] <= dmadr_imag_i;
                mem_f[wr_ptr]  <= pf[RD_LATENCY-1];
                mem_l[wr_ptr]  <= pl[RD_LATENCY-1];
                wr_ptr         <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            if (push && !pop)      fcount <= fcount + 1'b1;
            else if (!push && pop) fcount <= fcount - 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst_n) assert (!(push && !pop && fcount == 5'(DEPTH)));
    end

`ifdef R2FFT_DMARD_BITREV_EN
    assign dmaa_o = bitrev(cnt_q);
`else
    assign dmaa_o = cnt_q;
`endif

    assign dmaact_o  = issue;
    assign m_real_o  = mem_re[rd_ptr];
    assign m_imag_o  = mem_im[rd_ptr];
    assign m_first_o = m_valid_o && mem_f[rd_ptr];
    assign m_last_o  = m_valid_o && mem_l[rd_ptr];
    assign m_exp_o   = exp_q;
    assign busy_o    = (state_q != IDLE);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_r2fft_dma_reader.sv
// Bench for r2fft_dma_reader: 16-point frames, 3-cycle DMA memory model,
// stream scoreboard with random backpressure, overrun and mid-frame reset.
module tb_r2fft_dma_reader;

    localparam int LEN = 16;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic done_i;
    logic signed [7:0] bfpexp_i;
    logic dmaact_o;
    logic [3:0] dmaa_o;
    logic signed [DW-1:0] dmadr_real_i, dmadr_imag_i;
    logic m_valid_o, m_ready_i;
    logic signed [DW-1:0] m_real_o, m_imag_o;
    logic m_first_o, m_last_o;
    logic signed [7:0] m_exp_o;
    logic busy_o, overrun_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [DW-1:0] mem_re [LEN];
    logic signed [DW-1:0] mem_im [LEN];

    always #5 clk = ~clk;

    r2fft_dma_reader #(
        .FFT_LENGTH(LEN),
        .FFT_DW(DW),
        .RD_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .done_i(done_i),
        .bfpexp_i(bfpexp_i),
        .dmaact_o(dmaact_o),
        .dmaa_o(dmaa_o),
        .dmadr_real_i(dmadr_real_i),
        .dmadr_imag_i(dmadr_imag_i),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .m_real_o(m_real_o),
        .m_imag_o(m_imag_o),
        .m_first_o(m_first_o),
        .m_last_o(m_last_o),
        .m_exp_o(m_exp_o),
        .busy_o(busy_o),
        .overrun_o(overrun_o)
    );

    // DMA memory: data for a strobe seen in cycle k is driven in cycle k+LAT
    logic hv [LAT+1];
    logic [3:0] ha [LAT+1];
    initial begin
        for (int i = 0; i <= LAT; i++) begin
            hv[i] = 1'b0;
            ha[i] = '0;
        end
        dmadr_real_i = '0;
        dmadr_imag_i = '0;
    end

    always @(negedge clk) begin
        #2;
        for (int i = LAT; i > 0; i--) begin
            hv[i] = hv[i-1];
            ha[i] = ha[i-1];
        end
        hv[0] = dmaact_o;
        ha[0] = dmaa_o;
        if (hv[LAT]) begin
            dmadr_real_i = mem_re[ha[LAT]];
            dmadr_imag_i = mem_im[ha[LAT]];
        end else begin
            dmadr_real_i = DW'($urandom);
            dmadr_imag_i = DW'($urandom);
        end
    end

    function automatic logic [3:0] addr_of(input int i);
        logic [3:0] n;
        logic [3:0] r;
        n = 4'(i);
`ifdef R2FFT_DMARD_BITREV_EN
        for (int b = 0; b < 4; b++) r[b] = n[3-b];
`else
        r = n;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_act"}, dmaact_o, 0);
        chk({tag, "_addr"}, dmaa_o, 0);
        chk({tag, "_vld"}, m_valid_o, 0);
        chk({tag, "_first"}, m_first_o, 0);
        chk({tag, "_last"}, m_last_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_ovr"}, overrun_o, 0);
        chk({tag, "_re"}, m_real_o, 0);
        chk({tag, "_im"}, m_imag_o, 0);
        chk({tag, "_exp"}, m_exp_o, 0);
    endtask

    // mode 0: ready=1, 1: random ready, 2: ready low for cycles 1..20
    task automatic run_frame(input int mode, input bit ovr,
                             input int abort_k, input logic signed [7:0] e);
        int k, na, s20;
        bit mbusy, pend, pendn, fin, stall;
        logic signed [DW-1:0] p_re, p_im;
        logic p_f, p_l;
        for (int a = 0; a < LEN; a++) begin
            mem_re[a] = DW'($urandom);
            mem_im[a] = DW'($urandom);
        end
        bfpexp_i  = e;
        done_i    = 1'b1;
        m_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_i   = 1'b0;
        bfpexp_i = e + 8'sd3;
        k = 0; na = 0; s20 = 0;
        mbusy = 1; pend = 0; pendn = 0; fin = 0; stall = 0;
        p_re = '0; p_im = '0; p_f = 0; p_l = 0;
        for (int c = 1; c < 400; c++) begin
            if (abort_k >= 0 && k == abort_k) begin
                rst_n = 1'b0;
                #1;
                chk_zero("midrst");
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            fin = !mbusy;
            case (mode)
                0: m_ready_i = 1'b1;
                1: m_ready_i = 1'($urandom_range(0, 1));
                default: m_ready_i = (c > 20);
            endcase
            #1;
            chk("busy", busy_o, mbusy);
            chk("overrun", overrun_o, pend);
            chk("exp", m_exp_o, e);
            if (mode == 0) begin
                chk("t_act", dmaact_o, c <= 16);
                chk("t_vld", m_valid_o, c >= 5 && c <= 20);
                chk("t_first", m_first_o, c == 5);
                chk("t_last", m_last_o, c == 20);
            end
            if (stall) begin
                chk("stall_vld", m_valid_o, 1);
                chk("stall_re", m_real_o, p_re);
                chk("stall_im", m_imag_o, p_im);
                chk("stall_fl", {m_first_o, m_last_o}, {p_f, p_l});
            end
            if (dmaact_o) begin
                chk("addr", dmaa_o, addr_of(na));
                na++;
                if (c <= 20) s20++;
            end
            if (mode == 2 && c == 20) chk("strobes_stalled", s20, 4);
            if (m_valid_o && m_ready_i) begin
                chk("re", m_real_o, mem_re[addr_of(k)]);
                chk("im", m_imag_o, mem_im[addr_of(k)]);
                chk("first", m_first_o, k == 0);
                chk("last", m_last_o, k == LEN - 1);
                if (k == LEN - 1) begin
                    mbusy = 0;
                    if (ovr) begin
                        done_i = 1'b1;
                        pendn  = 1;
                    end
                end
                k++;
            end
            if (ovr && c == 3) begin
                done_i = 1'b1;
                pendn  = 1;
            end
            stall = m_valid_o && !m_ready_i;
            p_re = m_real_o;
            p_im = m_imag_o;
            p_f  = m_first_o;
            p_l  = m_last_o;
            @(posedge clk);
            @(negedge clk);
            done_i = 1'b0;
            pend   = pendn;
            pendn  = 0;
            if (fin) break;
        end
        chk("words", k, LEN);
        chk("strobes", na, LEN);
    endtask

    initial begin
        rst_n     = 1'b0;
        done_i    = 1'b0;
        m_ready_i = 1'b0;
        bfpexp_i  = 8'sd0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, 0, -1, -8'sd2);
        run_frame(1, 0, -1, 8'($urandom));
        run_frame(1, 0, -1, 8'($urandom));
        run_frame(2, 0, -1, 8'($urandom));
        run_frame(0, 1, -1, 8'sd5);
        run_frame(1, 0, 7, 8'($urandom));
        run_frame(0, 0, -1, 8'($urandom));
        run_frame(1, 0, -1, -8'sd128);
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/r2fft_dma_reader.md
R2FFT_DMA_READER -- requirements
Module: r2fft_dma_reader

Interface
REQ-001 The module SHALL have parameter FFT_LENGTH, default 1024, giving the frame length (2^N, at least 4).
REQ-002 The module SHALL have parameter FFT_DW, default 16, giving the data bitwidth per real/imag component.
REQ-003 The module SHALL have parameter RD_LATENCY, default 3, giving cycles from dmaact_o/dmaa_o to valid dmadr_*_i (range 1-8).
REQ-004 The module SHALL have local parameter FFT_N = clog2(FFT_LENGTH), which is not overridable.
REQ-005 The module SHALL have the following ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- done_i  in  1  one-cycle pulse from the FFT core: frame complete.
- bfpexp_i  in  8 (signed)  block-floating-point exponent, valid with done_i.
- dmaact_o  out  1  read strobe to the FFT DMA bus.
- dmaa_o  out  FFT_N  read address to the FFT DMA bus.
- dmadr_real_i / dmadr_imag_i  in  FFT_DW each (signed)  read data, RD_LATENCY cycles after the strobe.
- m_valid_o  out  1  output stream valid.
- m_ready_i  in  1  output stream ready.
- m_real_o / m_imag_o  out  FFT_DW each (signed)  output sample.
- m_first_o / m_last_o  out  1 each  asserted on bin 0 / bin FFT_LENGTH-1.
- m_exp_o  out  8 (signed)  frame exponent, constant across the frame.
- busy_o  out  1  high while not IDLE.
- overrun_o  out  1  one-cycle pulse when done_i is dropped.

Function
REQ-006 The FSM SHALL have three states: IDLE, READ and DRAIN.
REQ-007 In IDLE, done_i SHALL latch bfpexp_i into m_exp_o, clear the address counter, and move to READ.
REQ-008 In READ, one read SHALL issue per cycle (dmaact_o=1, dmaa_o=counter) whenever inflight+fifo_count < RD_LATENCY+1; the counter then increments.
REQ-009 The cycle that issues address FFT_LENGTH-1 SHALL move the FSM to DRAIN; the counter SHALL NOT wrap within a frame.
REQ-010 A RD_LATENCY-deep shift register SHALL track strobes; each tagged return SHALL push {real, imag, first, last} into an internal FIFO of depth RD_LATENCY+1.
REQ-011 The FIFO SHALL never overflow; push when full is a design error and SHALL be asserted against in simulation.
REQ-012 m_valid_o SHALL equal "FIFO not empty" from a registered FIFO head; m_* SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-013 A word SHALL transfer when m_valid_o and m_ready_i are both high; simultaneous push and pop SHALL keep the count unchanged.
REQ-014 In DRAIN, transfer of the word with m_last_o=1 SHALL return the FSM to IDLE in the next cycle.
REQ-015 done_i in READ or DRAIN, including the cycle of the final transfer, SHALL be ignored and SHALL pulse overrun_o for one cycle.
REQ-016 With m_ready_i held at 1, done_i at cycle 0 SHALL give dmaact_o at cycle 1, first m_valid_o at cycle RD_LATENCY+2, and FFT_LENGTH consecutive valid cycles.
REQ-017 m_exp_o SHALL change only on an accepted done_i.

Reset
REQ-018 rst_n=0 SHALL asynchronously force the following, at any time including mid-frame:
- FSM to IDLE.
- counter, inflight tags and FIFO pointers to 0.
- dmaact_o, dmaa_o, m_valid_o, m_first_o, m_last_o, busy_o, overrun_o to 0.
- m_real_o, m_imag_o, m_exp_o to 0.
REQ-019 Reset deassertion SHALL take effect on the next rising clk; no output SHALL glitch high during reset.

Configuration
REQ-020 Macro R2FFT_DMARD_BITREV_EN, when defined, SHALL drive dmaa_o with the FFT_N-bit bit-reversal of the counter; first/last SHALL still follow issue order.
REQ-021 Without R2FFT_DMARD_BITREV_EN, dmaa_o SHALL equal the counter (natural order); all other behaviour SHALL be identical.

Verification
REQ-022 FFT_LENGTH=16, RD_LATENCY=3, m_ready=1, done_i with bfpexp_i=-2 -> dmaa_o 0..15 on cycles 1..16; m_valid_o on cycles 5..20; m_first_o on cycle 5; m_last_o on cycle 20; m_exp_o=-2.
REQ-023 m_ready_i toggled by random pattern (50%) -> all 16 words delivered once, in order, data matching the memory model, no FIFO overflow, m_* stable while stalled.
REQ-024 m_ready_i=0 for 20 cycles after done_i -> exactly 4 strobes issued, then dmaact_o=0 until ready returns.
REQ-025 done_i pulsed in READ and again on the final-transfer cycle -> overrun_o pulses twice, m_exp_o unchanged, FSM returns to IDLE.
REQ-026 rst_n low at word 7 -> all outputs 0 immediately; the next done_i gives a clean full frame starting at address 0.
REQ-027 With R2FFT_DMARD_BITREV_EN, FFT_LENGTH=16 -> dmaa_o sequence 0,8,4,12,2,...,15.
